// File: rtl/unsigned_mul_ha_pipe.sv
// unsigned_mul_ha_pipe: 3-stage unsigned WxW multiplier built from paired half-adder partial-product rows.
// Define APPROX_HA_EN to replace overlap columns 1..APPROX_COLS of every pair with OR cells.
module unsigned_mul_ha_pipe #(
  parameter int W = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);
`ifdef APPROX_HA_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif
  localparam int AC = APPROX ? APPROX_COLS : 0;
  localparam int PW = 2 * W;
  localparam int NP = W / 2;

  logic           r_s0_v, r_s1_v, r_s2_v;
  logic [W-1:0]   r_x, r_y;
  logic [W:0]     r_t [NP];
  logic [W-2:0]   r_bo [NP];
  logic [PW-1:0]  r_p;
  logic [W:0]     w_t [NP];
  logic [W-2:0]   w_bo [NP];
  logic [PW-1:0]  w_sum;
  logic           w_rdy0, w_rdy1, w_rdy2;

  assign w_rdy2    = ~r_s2_v | out_ready;
  assign w_rdy1    = ~r_s1_v | w_rdy2;
  assign w_rdy0    = ~r_s0_v | w_rdy1;
  assign in_ready  = w_rdy0;
  assign out_valid = r_s2_v;
  assign p         = r_p;
  assign busy      = r_s0_v | r_s1_v | r_s2_v;

  // Row b is kept with its natural weight: w_b[c] = y[c-1] & x[2k+1].
  for (genvar k = 0; k < NP; k++) begin : g_pair
    logic [W-1:0] w_a;
    logic [W:1]   w_b;
    assign w_a = r_x[2*k] ? r_y : '0;
    assign w_b = r_x[2*k+1] ? r_y : '0;
    assign w_t[k][0] = w_a[0];
    assign w_t[k][W] = w_b[W];
    for (genvar c = 1; c < W; c++) begin : g_col
      if (c <= AC) begin : g_or
        assign w_t[k][c]    = w_a[c] | w_b[c];
        assign w_bo[k][c-1] = 1'b0;
      end else begin : g_ha
        assign w_t[k][c]    = w_a[c] ^ w_b[c];
        assign w_bo[k][c-1] = w_a[c] & w_b[c];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NP; k++)
      w_sum = w_sum + ((PW'(r_t[k]) + (PW'(r_bo[k]) << 2)) << (2 * k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_v <= 1'b0;
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_p    <= '0;
    end else begin
      if (w_rdy0) r_s0_v <= in_valid;
      if (w_rdy1) r_s1_v <= r_s0_v;
      if (w_rdy2) r_s2_v <= r_s1_v;
      if (w_rdy2 && r_s1_v) r_p <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && w_rdy0) begin
      r_x <= x;
      r_y <= y;
    end
    if (w_rdy1 && r_s0_v) begin
      r_t  <= w_t;
      r_bo <= w_bo;
    end
  end
endmodule
